// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: WIDTH iterations over operand magnitudes, sign fixed up
// in a final DONE cycle, optional accumulate into the held 2*WIDTH-bit result.
module seq_mul #(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic               acc,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               mulfinish,
    output logic [2*WIDTH-1:0] y
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_pp;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_acc;
    logic [2*WIDTH-1:0] r_y;
    logic               r_busy;
    logic               r_fin;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_pp_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_y_next;
    logic               w_busy_next;
    logic               w_fin_next;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start)  w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // busy/mulfinish are registered from the next state so start never reaches them combinationally
    always_comb begin
        w_busy_next = (w_next != S_IDLE);
        w_fin_next  = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_fin  <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_fin  <= w_fin_next;
        end
    end

    // Most-negative operand negates to 2^(WIDTH-1), which is still exact when read unsigned
    always_comb begin
        w_mag_a   = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        w_mag_b   = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
        w_pp_step = r_mplier[0] ? (r_pp + r_mcand) : r_pp;
        w_prod    = r_neg ? (~r_pp + 1'b1) : r_pp;
        w_y_next  = r_acc ? (r_y + w_prod) : w_prod;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_pp     <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_acc    <= 1'b0;
            r_y      <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_pp     <= '0;
                        r_cnt    <= '0;
                        r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= acc;
                    end
                end
                S_RUN: begin
                    r_pp     <= w_pp_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                S_DONE: begin
                    r_y <= w_y_next;
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign mulfinish = r_fin;
    assign y         = r_y;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_seq_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        s_start = 1'b0, s_sgn = 1'b0, s_acc = 1'b0;
    logic [31:0] s_a = '0, s_b = '0;
    logic        busy32, fin32;
    logic [63:0] y32;

    logic        t_start = 1'b0, t_sgn = 1'b0, t_acc = 1'b0;
    logic [7:0]  t_a = '0, t_b = '0;
    logic        busy8, fin8;
    logic [15:0] y8;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] m_y32 = '0;
    logic [15:0] m_y8  = '0;

    always #5 clk = ~clk;

    seq_mul #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .is_signed(s_sgn), .acc(s_acc),
        .a(s_a), .b(s_b), .busy(busy32), .mulfinish(fin32), .y(y32)
    );

    seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(t_start), .is_signed(t_sgn), .acc(t_acc),
        .a(t_a), .b(t_b), .busy(busy8), .mulfinish(fin8), .y(y8)
    );

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint x, z;
        x = s ? longint'($signed(a)) : longint'({32'b0, a});
        z = s ? longint'($signed(b)) : longint'({32'b0, b});
        return 64'(x * z);
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int x, z;
        x = s ? int'($signed(a)) : int'({24'b0, a});
        z = s ? int'($signed(b)) : int'({24'b0, b});
        return 16'(x * z);
    endfunction

    // Issues one op and waits (bounded) for mulfinish; lat = edges from accept to mulfinish.
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s, input logic ac,
                         input bit wait_neg, output int lat, output logic b_acc, output logic f_acc);
        if (wait_neg) @(negedge clk);
        s_start = 1'b1; s_a = a; s_b = b; s_sgn = s; s_acc = ac;
        @(posedge clk); #1;
        b_acc = busy32; f_acc = fin32;
        s_start = 1'b0; s_a = $urandom; s_b = $urandom; s_sgn = 1'($urandom); s_acc = 1'($urandom);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); lat++; #1;
            if (fin32) break;
        end
        m_y32 = ac ? m_y32 + ref32(a, b, s) : ref32(a, b, s);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ac,
                        input bit wait_neg, output int lat, output logic b_acc, output logic f_acc);
        if (wait_neg) @(negedge clk);
        t_start = 1'b1; t_a = a; t_b = b; t_sgn = s; t_acc = ac;
        @(posedge clk); #1;
        b_acc = busy8; f_acc = fin8;
        t_start = 1'b0; t_a = 8'($urandom); t_b = 8'($urandom); t_sgn = 1'($urandom); t_acc = 1'($urandom);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); lat++; #1;
            if (fin8) break;
        end
        m_y8 = ac ? m_y8 + ref8(a, b, s) : ref8(a, b, s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy32 !== 1'b0) $display("FAIL reset_busy32 got %b want 0", busy32); else n_pass++;
        n_checks++; if (fin32 !== 1'b0) $display("FAIL reset_fin32 got %b want 0", fin32); else n_pass++;
        n_checks++; if (y32 !== 64'h0) $display("FAIL reset_y32 got %h want 0", y32); else n_pass++;
        n_checks++; if ({busy8, fin8, y8} !== 18'h0) $display("FAIL reset_dut8 got %b_%b_%h want 0", busy8, fin8, y8); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        m_y32 = '0; m_y8 = '0;
    endtask

    task automatic test_basic();
        int lat; logic ba, fa;
        run32(32'd3, 32'd5, 1'b0, 1'b0, 1'b1, lat, ba, fa);
        n_checks++; if (ba !== 1'b1) $display("FAIL basic_busy_at_accept got %b want 1", ba); else n_pass++;
        n_checks++; if (lat != 33) $display("FAIL basic_latency got %0d want 33", lat); else n_pass++;
        n_checks++; if (y32 !== 64'h000000000000000F) $display("FAIL basic_y got %h want 000000000000000f", y32); else n_pass++;
        n_checks++; if (busy32 !== 1'b0) $display("FAIL basic_busy_at_finish got %b want 0", busy32); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (fin32 !== 1'b0) $display("FAIL basic_fin_one_cycle got %b want 0", fin32); else n_pass++;
    endtask

    task automatic test_signed();
        int lat; logic ba, fa;
        run32(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, 1'b1, lat, ba, fa);
        n_checks++; if (y32 !== 64'hFFFFFFFFFFFFFFF1) $display("FAIL signed_m3x5 got %h want fffffffffffffff1", y32); else n_pass++;
        run32(32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, 1'b1, lat, ba, fa);
        n_checks++; if (y32 !== 64'h00000004FFFFFFF1) $display("FAIL unsigned_fffffffdx5 got %h want 00000004fffffff1", y32); else n_pass++;
    endtask

    task automatic test_extremes();
        int lat; logic ba, fa;
        run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, lat, ba, fa);
        n_checks++; if (y32 !== 64'hFFFFFFFE00000001) $display("FAIL ext_umax got %h want fffffffe00000001", y32); else n_pass++;
        run32(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1, lat, ba, fa);
        n_checks++; if (y32 !== 64'h4000000000000000) $display("FAIL ext_smin_sq got %h want 4000000000000000", y32); else n_pass++;
        run32(32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b1, lat, ba, fa);
        n_checks++; if (y32 !== 64'hFFFFFFFF80000000) $display("FAIL ext_smin_x1 got %h want ffffffff80000000", y32); else n_pass++;
    endtask

    task automatic test_accumulate();
        int lat; logic ba, fa;
        run32(32'd3, 32'd5, 1'b0, 1'b0, 1'b1, lat, ba, fa);
        run32(32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 1'b0, lat, ba, fa);
        n_checks++; if (ba !== 1'b1) $display("FAIL b2b_accepted got busy %b want 1", ba); else n_pass++;
        n_checks++; if (fa !== 1'b0) $display("FAIL b2b_fin_dropped got %b want 0", fa); else n_pass++;
        n_checks++; if (lat != 33) $display("FAIL b2b_latency got %0d want 33", lat); else n_pass++;
        n_checks++; if (y32 !== 64'h000000000000000E) $display("FAIL acc_y got %h want 000000000000000e", y32); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int lat; int stray; logic [63:0] y_hold;
        @(negedge clk);
        s_start = 1'b1; s_a = 32'd9; s_b = 32'd11; s_sgn = 1'b0; s_acc = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        repeat (4) @(negedge clk);
        s_start = 1'b1; s_a = 32'd100; s_b = 32'd100; s_acc = 1'b1;
        repeat (2) @(negedge clk);
        s_start = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); lat++; #1;
            if (fin32) break;
        end
        m_y32 = 64'd99;
        n_checks++; if (lat != 27) $display("FAIL ignore_latency got %0d want 27", lat); else n_pass++;
        n_checks++; if (y32 !== m_y32) $display("FAIL ignore_y got %h want %h", y32, m_y32); else n_pass++;
        stray = 0; y_hold = y32;
        repeat (5) begin
            @(posedge clk); #1;
            if (busy32 !== 1'b0 || fin32 !== 1'b0 || y32 !== y_hold) stray++;
        end
        n_checks++; if (stray != 0) $display("FAIL ignore_not_queued got %0d bad cycles want 0", stray); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int lat; logic ba, fa;
        @(negedge clk);
        s_start = 1'b1; s_a = 32'h00012345; s_b = 32'hFFFF0777; s_sgn = 1'b1; s_acc = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy32 !== 1'b0) $display("FAIL abort_busy got %b want 0", busy32); else n_pass++;
        n_checks++; if (fin32 !== 1'b0) $display("FAIL abort_fin got %b want 0", fin32); else n_pass++;
        n_checks++; if (y32 !== 64'h0) $display("FAIL abort_y got %h want 0", y32); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        m_y32 = '0; m_y8 = '0;
        run32(32'd7, 32'd6, 1'b0, 1'b0, 1'b1, lat, ba, fa);
        n_checks++; if (lat != 33) $display("FAIL abort_next_latency got %0d want 33", lat); else n_pass++;
        n_checks++; if (y32 !== 64'd42) $display("FAIL abort_next_y got %h want 2a", y32); else n_pass++;
    endtask

    task automatic test_random32();
        int lat; logic ba, fa; logic [31:0] a, b; logic s, ac;
        logic [31:0] pool [4] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000};
        for (int i = 0; i < 16; i++) begin
            a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : 32'($urandom);
            s = 1'($urandom); ac = 1'($urandom);
            run32(a, b, s, ac, bit'($urandom), lat, ba, fa);
            n_checks++;
            if (y32 !== m_y32 || lat != 33)
                $display("FAIL rand32_%0d got y=%h lat=%0d want y=%h lat=33 (a=%h b=%h s=%b acc=%b)", i, y32, lat, m_y32, a, b, s, ac);
            else n_pass++;
        end
    endtask

    task automatic test_w8();
        int lat; logic ba, fa; logic [7:0] a, b; logic s, ac;
        run8(8'd3, 8'd5, 1'b0, 1'b0, 1'b1, lat, ba, fa);
        n_checks++; if (lat != 9) $display("FAIL w8_latency got %0d want 9", lat); else n_pass++;
        n_checks++; if (y8 !== 16'h000F) $display("FAIL w8_3x5 got %h want 000f", y8); else n_pass++;
        n_checks++; if (busy8 !== 1'b0) $display("FAIL w8_busy_at_finish got %b want 0", busy8); else n_pass++;
        run8(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, lat, ba, fa);
        n_checks++; if (y8 !== 16'hFE01) $display("FAIL w8_umax got %h want fe01", y8); else n_pass++;
        run8(8'h80, 8'h80, 1'b1, 1'b0, 1'b1, lat, ba, fa);
        n_checks++; if (y8 !== 16'h4000) $display("FAIL w8_smin_sq got %h want 4000", y8); else n_pass++;
        run8(8'h80, 8'h01, 1'b1, 1'b0, 1'b1, lat, ba, fa);
        n_checks++; if (y8 !== 16'hFF80) $display("FAIL w8_smin_x1 got %h want ff80", y8); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom); ac = 1'($urandom);
            run8(a, b, s, ac, bit'($urandom), lat, ba, fa);
            n_checks++;
            if (y8 !== m_y8 || lat != 9)
                $display("FAIL rand8_%0d got y=%h lat=%0d want y=%h lat=9 (a=%h b=%h s=%b acc=%b)", i, y8, lat, m_y8, a, b, s, ac);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_extremes();
        test_accumulate();
        test_busy_ignore();
        test_reset_abort();
        test_random32();
        test_w8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
